// File: rtl/core_l1d_resp.sv
// rtl/core_l1d_resp.sv - L1 data response block: local word array plus uncached port with timeout
// Define CORE_L1D_ALIGN_CHK_EN to turn misaligned half/word accesses into error responses.
module core_l1d_resp #(
  parameter int MEM_WORDS  = 1024,
  parameter int UC_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        l1d_req_val,
  input  logic [2:0]  l1d_req_cop,
  input  logic [2:0]  l1d_req_size,
  input  logic [31:0] l1d_req_addr,
  input  logic [31:0] l1d_req_wdata,
  output logic        l1d_req_ack,
  output logic        l1d_resp_val,
  output logic [31:0] l1d_resp_data,
  output logic        l1d_resp_err,
  output logic        uc_req_val,
  output logic        uc_req_we,
  output logic [31:0] uc_req_addr,
  output logic [31:0] uc_req_wdata,
  output logic [3:0]  uc_req_be,
  input  logic        uc_ack,
  input  logic [31:0] uc_rdata
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(UC_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CRESP, UCREQ, ERESP} state_t;

  state_t             state_q, state_d;
  logic [31:0]        mem [MEM_WORDS];
  logic [31:0]        resp_data_q;
  logic [CNT_W-1:0]   wait_cnt;

  logic               is_store, cop_rsvd, size_rsvd, misalign, req_err;
  logic               uc_timeout;
  logic [3:0]         req_be;
  logic [31:0]        req_wdata;
  logic [IDX_W-1:0]   idx;

  assign is_store  = (l1d_req_cop[1:0] == 2'b01);
  assign cop_rsvd  = l1d_req_cop[1];
  assign size_rsvd = l1d_req_size[2] | (l1d_req_size[1:0] == 2'b11);
`ifdef CORE_L1D_ALIGN_CHK_EN
  assign misalign  = ((l1d_req_size == 3'b001) && l1d_req_addr[0]) ||
                     ((l1d_req_size == 3'b010) && (l1d_req_addr[1:0] != 2'b00));
`else
  assign misalign  = 1'b0;
`endif
  assign req_err    = cop_rsvd | size_rsvd | misalign;
  assign idx        = l1d_req_addr[IDX_W+1:2];
  assign uc_timeout = (wait_cnt == CNT_W'(UC_TIMEOUT - 1));

  // Narrow stores are replicated so the byte enables alone select the lanes.
  always_comb begin
    req_be    = 4'b1111;
    req_wdata = l1d_req_wdata;
    case (l1d_req_size)
      3'b000: begin
        req_be    = 4'b0001 << l1d_req_addr[1:0];
        req_wdata = {4{l1d_req_wdata[7:0]}};
      end
      3'b001: begin
        req_be    = l1d_req_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{l1d_req_wdata[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = l1d_req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (l1d_req_ack) begin
          if (req_err)             state_d = ERESP;
          else if (l1d_req_cop[2]) state_d = CRESP;
          else                     state_d = UCREQ;
        end
      end
      UCREQ: begin
        // A completion in the timeout cycle still wins.
        if (uc_ack)          state_d = CRESP;
        else if (uc_timeout) state_d = ERESP;
      end
      CRESP:   state_d = IDLE;
      ERESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    l1d_req_ack   = (state_q == IDLE) && l1d_req_val && rst_n;
    l1d_resp_val  = (state_q == CRESP) || (state_q == ERESP);
    l1d_resp_err  = (state_q == ERESP);
    l1d_resp_data = (state_q == CRESP) ? resp_data_q : 32'h0;
    uc_req_val    = (state_q == UCREQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data_q  <= 32'h0;
      wait_cnt     <= '0;
      uc_req_we    <= 1'b0;
      uc_req_addr  <= 32'h0;
      uc_req_wdata <= 32'h0;
      uc_req_be    <= 4'h0;
    end else begin
      if (l1d_req_ack) begin
        resp_data_q <= 32'h0;
        if (!req_err && l1d_req_cop[2] && !is_store) begin
          resp_data_q <= mem[idx];
        end
        if (!req_err && !l1d_req_cop[2]) begin
          uc_req_we    <= is_store;
          uc_req_addr  <= l1d_req_addr;
          uc_req_wdata <= req_wdata;
          uc_req_be    <= req_be;
          wait_cnt     <= '0;
        end
      end
      if (state_q == UCREQ) begin
        if (uc_ack) resp_data_q <= uc_req_we ? 32'h0 : uc_rdata;
        else        wait_cnt    <= wait_cnt + CNT_W'(1);
      end
    end
  end

  // Array contents survive reset; only accepted cacheable stores write.
  always_ff @(posedge clk) begin
    if (l1d_req_ack && !req_err && l1d_req_cop[2] && is_store) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_core_l1d_resp.sv
// tb/tb_core_l1d_resp.sv - self-checking bench for core_l1d_resp
module tb_core_l1d_resp;
  localparam int MEMW = 64;
  localparam int UCT  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        l1d_req_val;
  logic [2:0]  l1d_req_cop;
  logic [2:0]  l1d_req_size;
  logic [31:0] l1d_req_addr;
  logic [31:0] l1d_req_wdata;
  logic        l1d_req_ack;
  logic        l1d_resp_val;
  logic [31:0] l1d_resp_data;
  logic        l1d_resp_err;
  logic        uc_req_val;
  logic        uc_req_we;
  logic [31:0] uc_req_addr;
  logic [31:0] uc_req_wdata;
  logic [3:0]  uc_req_be;
  logic        uc_ack;
  logic [31:0] uc_rdata;

  core_l1d_resp #(.MEM_WORDS(MEMW), .UC_TIMEOUT(UCT)) dut (
    .clk(clk), .rst_n(rst_n),
    .l1d_req_val(l1d_req_val), .l1d_req_cop(l1d_req_cop), .l1d_req_size(l1d_req_size),
    .l1d_req_addr(l1d_req_addr), .l1d_req_wdata(l1d_req_wdata), .l1d_req_ack(l1d_req_ack),
    .l1d_resp_val(l1d_resp_val), .l1d_resp_data(l1d_resp_data), .l1d_resp_err(l1d_resp_err),
    .uc_req_val(uc_req_val), .uc_req_we(uc_req_we), .uc_req_addr(uc_req_addr),
    .uc_req_wdata(uc_req_wdata), .uc_req_be(uc_req_be), .uc_ack(uc_ack), .uc_rdata(uc_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed storage, word index taken modulo the array depth.
  logic [7:0] mdl [MEMW][4];

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % MEMW);
  endfunction

  function automatic logic model_err(input logic [2:0] cop, input logic [2:0] sz, input logic [31:0] a);
    logic e;
    e = (cop[1:0] == 2'b10) || (cop[1:0] == 2'b11) || (sz > 3'd2);
`ifdef CORE_L1D_ALIGN_CHK_EN
    if ((sz == 3'd1) && (a % 2 != 0)) e = 1'b1;
    if ((sz == 3'd2) && (a % 4 != 0)) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    int w, lane;
    w = widx(a);
    lane = int'(a % 4);
    if (sz == 3'd0) mdl[w][lane] = d[7:0];
    else if (sz == 3'd1) begin
      lane = (lane >= 2) ? 2 : 0;
      mdl[w][lane]     = d[7:0];
      mdl[w][lane + 1] = d[15:8];
    end else begin
      for (int k = 0; k < 4; k++) mdl[w][k] = d[8*k +: 8];
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a);
    int w;
    w = widx(a);
    return {mdl[w][3], mdl[w][2], mdl[w][1], mdl[w][0]};
  endfunction

  // Single cached/error request: ack now, response exactly one cycle after accept.
  task automatic run_req(input logic [2:0] cop, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rdata, output logic rerr);
    @(negedge clk);
    l1d_req_val = 1'b1; l1d_req_cop = cop; l1d_req_size = sz;
    l1d_req_addr = a; l1d_req_wdata = wd;
    #1 chk("req_ack", {31'b0, l1d_req_ack}, 32'd1);
    @(posedge clk);
    #1 l1d_req_val = 1'b0;
    chk("resp_val", {31'b0, l1d_resp_val}, 32'd1);
    chk("uc_idle", {31'b0, uc_req_val}, 32'd0);
    rdata = l1d_resp_data;
    rerr  = l1d_resp_err;
    @(posedge clk);
    #1 chk("resp_drop", {31'b0, l1d_resp_val}, 32'd0);
    chk("data_idle", l1d_resp_data, 32'h0);
  endtask

  typedef struct {
    logic [2:0]  cop;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [31:0] rd, ed;
    logic        re, ee;
    int          hi;
    int          seen;

    tbl[0]  = '{3'b101, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{3'b100, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{3'b101, 3'd2, 32'h10, 32'h11223344, 1'b0, 32'h0};
    tbl[3]  = '{3'b101, 3'd0, 32'h13, 32'h000000A5, 1'b0, 32'h0};
    tbl[4]  = '{3'b100, 3'd2, 32'h10, 32'h0, 1'b0, 32'hA5223344};
    tbl[5]  = '{3'b101, 3'd1, 32'h12, 32'h0000BEEF, 1'b0, 32'h0};
    tbl[6]  = '{3'b100, 3'd2, 32'h10, 32'h0, 1'b0, 32'hBEEF3344};
    tbl[7]  = '{3'b111, 3'd2, 32'h10, 32'h0, 1'b1, 32'h0};
    tbl[8]  = '{3'b101, 3'd3, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h0};
    tbl[9]  = '{3'b100, 3'd2, 32'h10, 32'h0, 1'b0, 32'hBEEF3344};
    tbl[10] = '{3'b101, 3'd2, 32'h110, 32'hCAFEF00D, 1'b0, 32'h0};
    tbl[11] = '{3'b100, 3'd2, 32'hFFFFFF10, 32'h0, 1'b0, 32'hCAFEF00D};
`ifdef CORE_L1D_ALIGN_CHK_EN
    tbl[12] = '{3'b100, 3'd2, 32'h12, 32'h0, 1'b1, 32'h0};
    tbl[13] = '{3'b101, 3'd1, 32'h11, 32'h00001234, 1'b1, 32'h0};
    tbl[14] = '{3'b100, 3'd2, 32'h10, 32'h0, 1'b0, 32'hCAFEF00D};
`else
    tbl[12] = '{3'b100, 3'd2, 32'h12, 32'h0, 1'b0, 32'hCAFEF00D};
    tbl[13] = '{3'b101, 3'd1, 32'h11, 32'h00001234, 1'b0, 32'h0};
    tbl[14] = '{3'b100, 3'd2, 32'h10, 32'h0, 1'b0, 32'hCAFE1234};
`endif
    tbl[15] = '{3'b010, 3'd2, 32'h80000000, 32'h0, 1'b1, 32'h0};

    rst_n = 1'b0; uc_ack = 1'b0; uc_rdata = 32'h0;
    l1d_req_val = 1'b1; l1d_req_cop = 3'b100; l1d_req_size = 3'd2;
    l1d_req_addr = 32'h0; l1d_req_wdata = 32'h0;
    #12;
    chk("rst_ack", {31'b0, l1d_req_ack}, 32'd0);
    chk("rst_resp_val", {31'b0, l1d_resp_val}, 32'd0);
    chk("rst_resp_err", {31'b0, l1d_resp_err}, 32'd0);
    chk("rst_resp_data", l1d_resp_data, 32'h0);
    chk("rst_uc_val", {31'b0, uc_req_val}, 32'd0);
    chk("rst_uc_we", {31'b0, uc_req_we}, 32'd0);
    chk("rst_uc_addr", uc_req_addr, 32'h0);
    chk("rst_uc_wdata", uc_req_wdata, 32'h0);
    chk("rst_uc_be", {28'b0, uc_req_be}, 32'h0);
    @(negedge clk);
    l1d_req_val = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_req(tbl[i].cop, tbl[i].size, tbl[i].addr, tbl[i].wdata, rd, re);
      chk($sformatf("tbl%0d_err", i), {31'b0, re}, {31'b0, tbl[i].exp_err});
      chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp_data);
    end

    // Prefill so every model word is known, then randomized traffic.
    for (int i = 0; i < MEMW; i++) begin
      ed = $urandom;
      run_req(3'b101, 3'd2, 32'(i * 4), ed, rd, re);
      model_store(32'(i * 4), 3'd2, ed);
    end
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  cop, sz;
      logic [31:0] a, wd;
      int          r;
      r   = $urandom_range(0, 9);
      cop = (r < 4) ? 3'b100 : 3'b101;
      sz  = 3'($urandom_range(0, 2));
      if (r == 8) cop = {2'b11, 1'($urandom_range(0, 1))};
      if (r == 9) sz = 3'($urandom_range(3, 7));
      a  = $urandom;
      wd = $urandom;
      ee = model_err(cop, sz, a);
      ed = 32'h0;
      if (!ee && cop[1:0] == 2'b01) model_store(a, sz, wd);
      else if (!ee) ed = model_load(a);
      run_req(cop, sz, a, wd, rd, re);
      chk("rnd_err", {31'b0, re}, {31'b0, ee});
      chk("rnd_data", rd, ed);
    end

    // Back-to-back: second request held during the response cycle.
    @(negedge clk);
    l1d_req_val = 1'b1; l1d_req_cop = 3'b101; l1d_req_size = 3'd2;
    l1d_req_addr = 32'h20; l1d_req_wdata = 32'h01020304;
    #1 chk("b2b_ack0", {31'b0, l1d_req_ack}, 32'd1);
    @(posedge clk);
    #1 l1d_req_cop = 3'b100; l1d_req_wdata = 32'h0;
    chk("b2b_busy", {31'b0, l1d_req_ack}, 32'd0);
    chk("b2b_resp0", {31'b0, l1d_resp_val}, 32'd1);
    @(posedge clk);
    #1 chk("b2b_ack1", {31'b0, l1d_req_ack}, 32'd1);
    chk("b2b_gap", {31'b0, l1d_resp_val}, 32'd0);
    @(posedge clk);
    #1 l1d_req_val = 1'b0;
    chk("b2b_resp1", {31'b0, l1d_resp_val}, 32'd1);
    chk("b2b_data1", l1d_resp_data, 32'h01020304);
    model_store(32'h20, 3'd2, 32'h01020304);
    @(posedge clk);

    // Uncached load, completion in the fourth waiting cycle (also the timeout cycle).
    @(negedge clk);
    l1d_req_val = 1'b1; l1d_req_cop = 3'b000; l1d_req_size = 3'd2;
    l1d_req_addr = 32'h80000000; l1d_req_wdata = 32'h0;
    #1 chk("ucl_ack", {31'b0, l1d_req_ack}, 32'd1);
    @(posedge clk);
    #1 l1d_req_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ucl_val", {31'b0, uc_req_val}, 32'd1);
      chk("ucl_addr", uc_req_addr, 32'h80000000);
      chk("ucl_we_be", {27'b0, uc_req_we, uc_req_be}, 32'h0000000F);
      chk("ucl_noresp", {31'b0, l1d_resp_val}, 32'd0);
      if (i == 3) begin uc_ack = 1'b1; uc_rdata = 32'h12345678; end
      @(posedge clk);
      #1 uc_ack = 1'b0; uc_rdata = 32'hFFFFFFFF;
    end
    chk("ucl_resp", {31'b0, l1d_resp_val}, 32'd1);
    chk("ucl_err", {31'b0, l1d_resp_err}, 32'd0);
    chk("ucl_data", l1d_resp_data, 32'h12345678);
    chk("ucl_drop", {31'b0, uc_req_val}, 32'd0);
    @(posedge clk);
    #1 chk("ucl_done", {31'b0, l1d_resp_val}, 32'd0);

    // Uncached store acked at once: response carries no data.
    @(negedge clk);
    l1d_req_val = 1'b1; l1d_req_cop = 3'b001; l1d_req_size = 3'd1;
    l1d_req_addr = 32'h80000012; l1d_req_wdata = 32'h0000ABCD;
    @(posedge clk);
    #1 l1d_req_val = 1'b0;
    chk("ucs_we_be", {27'b0, uc_req_we, uc_req_be}, 32'h0000001C);
    chk("ucs_wdata", uc_req_wdata, 32'hABCDABCD);
    uc_ack = 1'b1; uc_rdata = 32'hDEAD0000;
    @(posedge clk);
    #1 uc_ack = 1'b0;
    chk("ucs_resp", {31'b0, l1d_resp_val}, 32'd1);
    chk("ucs_data", l1d_resp_data, 32'h0);
    @(posedge clk);

    // Uncached byte store that never completes: timeout error.
    @(negedge clk);
    l1d_req_val = 1'b1; l1d_req_cop = 3'b001; l1d_req_size = 3'd0;
    l1d_req_addr = 32'h80000005; l1d_req_wdata = 32'h0000005A;
    #1 chk("uct_ack", {31'b0, l1d_req_ack}, 32'd1);
    @(posedge clk);
    #1 l1d_req_val = 1'b0;
    chk("uct_fields", {uc_req_addr[7:0], 19'b0, uc_req_we, uc_req_be}, {8'h05, 19'b0, 1'b1, 4'b0010});
    chk("uct_wdata", uc_req_wdata, 32'h5A5A5A5A);
    hi = 0;
    for (int i = 0; i < 20 && uc_req_val; i++) begin
      hi++;
      @(posedge clk);
      #1;
    end
    chk("uct_cycles", 32'(hi), 32'd4);
    chk("uct_resp", {30'b0, l1d_resp_val, l1d_resp_err}, 32'd3);
    chk("uct_data", l1d_resp_data, 32'h0);
    @(posedge clk);
    #1 chk("uct_idle", {30'b0, l1d_resp_val, l1d_resp_err}, 32'd0);

    // Reset pulsed during UCREQ.
    @(negedge clk);
    l1d_req_val = 1'b1; l1d_req_cop = 3'b000; l1d_req_size = 3'd2;
    l1d_req_addr = 32'h90000000;
    @(posedge clk);
    #1 chk("rsu_val", {31'b0, uc_req_val}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rsu_drop", {31'b0, uc_req_val}, 32'd0);
    chk("rsu_addr", uc_req_addr, 32'h0);
    chk("rsu_ack", {31'b0, l1d_req_ack}, 32'd0);
    chk("rsu_resp", {31'b0, l1d_resp_val}, 32'd0);
    @(negedge clk);
    l1d_req_val = 1'b0; uc_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 if (l1d_resp_val || uc_req_val) seen++;
    end
    uc_ack = 1'b0;
    chk("rsu_quiet", 32'(seen), 32'd0);
    run_req(3'b100, 3'd2, 32'h20, 32'h0, rd, re);
    chk("rsu_next_data", rd, model_load(32'h20));
    chk("rsu_next_err", {31'b0, re}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/core_l1d_resp.md
CORE_L1D_RESP -- requirements
Module: core_l1d_resp

Interface
REQ-001 Parameter MEM_WORDS, default 1024, depth of the local 32-bit data array; SHALL be a power of two, 64 or more.
REQ-002 Parameter UC_TIMEOUT, default 255, maximum cycles to wait for uc_ack before an error response.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 l1d_req_val  input  1  request valid from the memory stage.
REQ-006 l1d_req_cop  input  3  [2] = cacheable (1) or uncacheable (0); [1:0] = 00 load, 01 store, others reserved.
REQ-007 l1d_req_size  input  3  000 byte, 001 half, 010 word; other codes are reserved.
REQ-008 l1d_req_addr  input  32  byte address.
REQ-009 l1d_req_wdata  input  32  store data, right-aligned.
REQ-010 l1d_req_ack  output  1  request accepted this cycle.
REQ-011 l1d_resp_val  output  1  one-cycle response strobe.
REQ-012 l1d_resp_data  output  32  load data, raw word aligned to the addressed word; zero for stores.
REQ-013 l1d_resp_err  output  1  error qualifier, valid with l1d_resp_val.
REQ-014 uc_req_val, uc_req_we, uc_req_addr[31:0], uc_req_wdata[31:0], uc_req_be[3:0]  outputs  uncached-port request.
REQ-015 uc_ack  input  1; uc_rdata  input  32  uncached-port completion.

Function
REQ-016 The block SHALL implement a finite-state machine with the states IDLE, CRESP, UCREQ and ERESP.
REQ-017 In IDLE, the block SHALL assert l1d_req_ack combinationally whenever l1d_req_val=1.
REQ-018 In CRESP, UCREQ and ERESP, l1d_req_ack SHALL be 0.
REQ-019 Cacheable accepted request: the FSM SHALL move IDLE->CRESP; in CRESP, l1d_resp_val=1 (one-cycle latency), then CRESP->IDLE.
REQ-020 Array index SHALL be addr[log2(MEM_WORDS)+1:2]; upper address bits SHALL be ignored.
REQ-021 Store byte enables: byte = 1<<addr[1:0]; half = 0011 or 1100 by addr[1]; word = 1111.
REQ-022 Store data SHALL be replicated across lanes: byte to all four lanes, half to both halves.
REQ-023 A cacheable store SHALL write only the enabled bytes at the accept edge.
REQ-024 A cacheable load SHALL return the full word; sign or zero extension is done downstream.
REQ-025 Uncacheable accepted request: the FSM SHALL move IDLE->UCREQ.
REQ-026 In UCREQ, uc_req_val=1 and the uc_req_* fields SHALL be registered at the accept edge and held stable until uc_ack.
REQ-027 On uc_ack in UCREQ: the block SHALL assert l1d_resp_val in the next cycle with resp_data = uc_rdata (captured), or 0 for a store, and then return to IDLE.
REQ-028 A wait counter SHALL reset at entry to UCREQ and increment each cycle without uc_ack.
REQ-029 When the wait counter reaches UC_TIMEOUT, the FSM SHALL go UCREQ->ERESP and drop uc_req_val.
REQ-030 In ERESP, l1d_resp_val=1 and l1d_resp_err=1, then ERESP->IDLE.
REQ-031 If uc_ack and the timeout occur in the same cycle, uc_ack SHALL take priority.
REQ-032 A reserved cop[1:0] or a reserved size code SHALL be accepted, SHALL cause no memory or uncached access, and SHALL move IDLE->ERESP.
REQ-033 l1d_resp_err SHALL be 0 on every non-error response.
REQ-034 l1d_resp_data SHALL be 0 whenever l1d_resp_val=0.
REQ-035 Back-to-back requests: a request presented in the response cycle SHALL be acked in the following IDLE cycle, giving a throughput of one request per 2 cycles.

Reset
REQ-036 While rst_n=0, the FSM SHALL be in IDLE and l1d_req_ack, l1d_resp_val, l1d_resp_err, l1d_resp_data, uc_req_val, uc_req_we, uc_req_addr, uc_req_wdata, uc_req_be and the wait counter SHALL all be 0.
REQ-037 Array contents SHALL NOT be reset.
REQ-038 Reset asserted mid-transaction SHALL abort the transaction and drop uc_req_val immediately; no response SHALL be issued after reset.

Configuration
REQ-039 The macro CORE_L1D_ALIGN_CHK_EN SHALL select misaligned-access checking.
REQ-040 With CORE_L1D_ALIGN_CHK_EN defined, a half with addr[0]=1 or a word with addr[1:0]!=00 SHALL be accepted and routed to ERESP with no memory or uncached access.
REQ-041 Without CORE_L1D_ALIGN_CHK_EN, misaligned accesses SHALL use the byte enables of REQ-021, and the low address bits SHALL be ignored for the word case.

Verification
REQ-042 Reset, then a cacheable word store (addr 0x10, data 0xDEADBEEF), then a cacheable word load of 0x10 -> each request acked in one cycle, response one cycle later, load resp_data=0xDEADBEEF, err=0.
REQ-043 Byte store 0xA5 to 0x13 over the word 0x11223344, then a word load -> resp_data=0xA5223344.
REQ-044 Uncacheable load of 0x8000_0000 with uc_ack after 3 cycles and uc_rdata=0x12345678 -> uc_req_val high for 4 cycles with fields stable, resp_val one cycle after uc_ack, resp_data=0x12345678.
REQ-045 Uncacheable store with uc_ack never asserted, UC_TIMEOUT=4 -> uc_req_val drops after 4 waiting cycles, resp_val=1 with err=1, FSM back in IDLE.
REQ-046 Reserved cop=2'b11, and separately a word load at 0x2 with CORE_L1D_ALIGN_CHK_EN defined -> err response, uc_req_val never asserted, array unchanged.
REQ-047 rst_n pulsed low during UCREQ -> uc_req_val=0 immediately, no resp_val afterwards, next request serviced normally.
